layer_compositor: RTL and testbench

//  Parametrised N-layer pixel compositor: the generalised successor of the fixed single-watermark output mux.

---
 rtl/layer_compositor_if.sv | 37 +++
 rtl/layer_compositor.sv | 273 +++++++++++++++++++++++++++
 tb/tb_layer_compositor.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_compositor_if.sv
// Pixel-domain bundle between the content generators, the compositor and the DVI transmitter.
// master drives video/layer inputs and reads the composited pixel; slave is the compositor.
interface layer_compositor_if #(
    parameter int NUM_LAYERS = 4,
    parameter int CW         = 8,
    parameter int AW         = 8
);
    logic                         i_de;
    logic                         i_hs;
    logic                         i_vs;
    logic                         i_frame_start;
    logic [NUM_LAYERS*3*CW-1:0]   i_layer_rgb;
    logic [NUM_LAYERS*AW-1:0]     i_layer_alpha;
    logic [NUM_LAYERS-1:0]        i_layer_active;
    logic [NUM_LAYERS-1:0]        i_layer_en;
    logic                         i_fade_req;
    logic                         o_de;
    logic                         o_hs;
    logic                         o_vs;
    logic [CW-1:0]                o_r;
    logic [CW-1:0]                o_g;
    logic [CW-1:0]                o_b;
    logic                         o_swap;
    logic                         o_busy;

    modport master (
        output i_de, i_hs, i_vs, i_frame_start, i_layer_rgb, i_layer_alpha,
               i_layer_active, i_layer_en, i_fade_req,
        input  o_de, o_hs, o_vs, o_r, o_g, o_b, o_swap, o_busy
    );

    modport slave (
        input  i_de, i_hs, i_vs, i_frame_start, i_layer_rgb, i_layer_alpha,
               i_layer_active, i_layer_en, i_fade_req,
        output o_de, o_hs, o_vs, o_r, o_g, o_b, o_swap, o_busy
    );
endinterface

// File: rtl/layer_compositor.sv
// N-layer alpha-blend compositor over a constant background, followed by a frame-paced
// fade gain stage and a fade-out / swap / fade-in sequencer. One pixel per clock, latency N+1.
module layer_compositor #(
    parameter int                NUM_LAYERS = 4,
    parameter int                CW         = 8,
    parameter int                AW         = 8,
    parameter logic [3*CW-1:0]   BG_RGB     = 24'h1A0A2E,
    parameter int                FADE_STEP  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    layer_compositor_if.slave     px
);

    localparam int             PW    = 3 * CW;
    localparam logic [AW-1:0]  G_MAX = {AW{1'b1}};
    localparam logic [AW-1:0]  STEP  = AW'(FADE_STEP);
    localparam logic [AW:0]    A_ONE = {1'b1, {AW{1'b0}}};

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FADE_OUT = 2'd1;
    localparam logic [1:0] S_HOLD     = 2'd2;
    localparam logic [1:0] S_FADE_IN  = 2'd3;

    // Rounding-up of the top code makes alpha=max an exact 2^AW weight.
    function automatic logic [CW-1:0] blend_ch(input logic [CW-1:0] fg,
                                               input logic [CW-1:0] under,
                                               input logic [AW-1:0] alpha);
        logic [AW:0]    a_eff;
        logic [CW+AW:0] acc;
        a_eff = {1'b0, alpha} + {{AW{1'b0}}, alpha[AW-1]};
        acc   = ({{(AW+1){1'b0}}, fg} * {{CW{1'b0}}, a_eff})
              + ({{(AW+1){1'b0}}, under} * {{CW{1'b0}}, (A_ONE - a_eff)});
        return acc[AW +: CW];
    endfunction

    function automatic logic [PW-1:0] blend_px(input logic [PW-1:0] fg,
                                               input logic [PW-1:0] under,
                                               input logic [AW-1:0] alpha);
        logic [PW-1:0] res;
        res = '0;
        for (int c = 0; c < 3; c++) begin
            res[c*CW +: CW] = blend_ch(fg[c*CW +: CW], under[c*CW +: CW], alpha);
        end
        return res;
    endfunction

    function automatic logic [CW-1:0] gain_ch(input logic [CW-1:0] pix,
                                              input logic [AW-1:0] g);
        logic [AW:0]    g_eff;
        logic [CW+AW:0] prod;
        g_eff = {1'b0, g} + {{AW{1'b0}}, g[AW-1]};
        prod  = {{(AW+1){1'b0}}, pix} * {{CW{1'b0}}, g_eff};
        return prod[AW +: CW];
    endfunction

    // Stage k blends layer k; each stage forwards only the layers still above it.
    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_stage
        localparam int NIN = NUM_LAYERS - k;

        logic [NIN*PW-1:0] rgb_in_s;
        logic [NIN*AW-1:0] alpha_in_s;
        logic [NIN-1:0]    act_in_s;
        logic [NIN-1:0]    en_in_s;
        logic [PW-1:0]     under_s;
        logic              de_in_s;
        logic              hs_in_s;
        logic              vs_in_s;
        logic [PW-1:0]     pix_d;
        logic [PW-1:0]     pix_q;
        logic              de_q;
        logic              hs_q;
        logic              vs_q;

        if (k == 0) begin : g_src
            assign rgb_in_s   = px.i_layer_rgb;
            assign alpha_in_s = px.i_layer_alpha;
            assign act_in_s   = px.i_layer_active;
            assign en_in_s    = px.i_layer_en;
            assign under_s    = BG_RGB;
            assign de_in_s    = px.i_de;
            assign hs_in_s    = px.i_hs;
            assign vs_in_s    = px.i_vs;
        end else begin : g_src
            assign rgb_in_s   = g_stage[k-1].g_carry.rgb_q;
            assign alpha_in_s = g_stage[k-1].g_carry.alpha_q;
            assign act_in_s   = g_stage[k-1].g_carry.act_q;
            assign en_in_s    = g_stage[k-1].g_carry.en_q;
            assign under_s    = g_stage[k-1].pix_q;
            assign de_in_s    = g_stage[k-1].de_q;
            assign hs_in_s    = g_stage[k-1].hs_q;
            assign vs_in_s    = g_stage[k-1].vs_q;
        end

        // Blend this stage's layer over the incoming pixel when it is active and enabled.
        always_comb begin
            pix_d = under_s;
            if (act_in_s[0] && en_in_s[0]) begin
                pix_d = blend_px(rgb_in_s[PW-1:0], under_s, alpha_in_s[AW-1:0]);
            end else begin
                pix_d = under_s;
            end
        end

        // Pixel and sync pipeline register for this stage.
        always_ff @(posedge clk) begin
            if (rst) begin
                pix_q <= '0;
                de_q  <= 1'b0;
                hs_q  <= 1'b0;
                vs_q  <= 1'b0;
            end else begin
                pix_q <= pix_d;
                de_q  <= de_in_s;
                hs_q  <= hs_in_s;
                vs_q  <= vs_in_s;
            end
        end

        if (NIN > 1) begin : g_carry
            logic [(NIN-1)*PW-1:0] rgb_q;
            logic [(NIN-1)*AW-1:0] alpha_q;
            logic [NIN-2:0]        act_q;
            logic [NIN-2:0]        en_q;

            // Carry the not-yet-blended layers alongside their pixel.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rgb_q   <= '0;
                    alpha_q <= '0;
                    act_q   <= '0;
                    en_q    <= '0;
                end else begin
                    rgb_q   <= rgb_in_s[NIN*PW-1:PW];
                    alpha_q <= alpha_in_s[NIN*AW-1:AW];
                    act_q   <= act_in_s[NIN-1:1];
                    en_q    <= en_in_s[NIN-1:1];
                end
            end
        end
    end

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] gain_q, gain_d;
    logic          swap_q, swap_d;
    logic          busy_q, busy_d;

    // Fade sequencer: gain only moves on frame_start, using the state held before that edge.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        swap_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                gain_d = G_MAX;
                if (px.i_fade_req) begin
                    state_d = S_FADE_OUT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FADE_OUT: begin
                if (px.i_frame_start) begin
                    if (gain_q > STEP) begin
                        gain_d = gain_q - STEP;
                    end else begin
                        gain_d  = {AW{1'b0}};
                        state_d = S_HOLD;
                    end
                end else begin
                    gain_d = gain_q;
                end
            end
            S_HOLD: begin
                if (px.i_frame_start) begin
                    swap_d  = 1'b1;
                    state_d = S_FADE_IN;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_FADE_IN: begin
                // A new request reverses direction from wherever the gain currently is.
                if (px.i_fade_req) begin
                    state_d = S_FADE_OUT;
                end else if (px.i_frame_start) begin
                    if ((G_MAX - gain_q) > STEP) begin
                        gain_d = gain_q + STEP;
                    end else begin
                        gain_d  = G_MAX;
                        state_d = S_IDLE;
                    end
                end else begin
                    gain_d = gain_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                gain_d  = G_MAX;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Fade sequencer state, gain and handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gain_q  <= G_MAX;
            swap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            swap_q  <= swap_d;
            busy_q  <= busy_d;
        end
    end

    logic [PW-1:0] last_pix_s;
    logic          last_de_s;
    logic [CW-1:0] r_d, g_d, b_d;
    logic [CW-1:0] r_q, g_q, b_q;
    logic          de_q, hs_q, vs_q;

    assign last_pix_s = g_stage[NUM_LAYERS-1].pix_q;
    assign last_de_s  = g_stage[NUM_LAYERS-1].de_q;

    // Gain stage; blanking forces black.
    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (last_de_s) begin
            r_d = gain_ch(last_pix_s[2*CW +: CW], gain_q);
            g_d = gain_ch(last_pix_s[CW +: CW], gain_q);
            b_d = gain_ch(last_pix_s[0 +: CW], gain_q);
        end else begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            de_q <= 1'b0;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
            de_q <= last_de_s;
            hs_q <= g_stage[NUM_LAYERS-1].hs_q;
            vs_q <= g_stage[NUM_LAYERS-1].vs_q;
        end
    end

    assign px.o_r    = r_q;
    assign px.o_g    = g_q;
    assign px.o_b    = b_q;
    assign px.o_de   = de_q;
    assign px.o_hs   = hs_q;
    assign px.o_vs   = vs_q;
    assign px.o_swap = swap_q;
    assign px.o_busy = busy_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: blending, latency, masking and the fade sequencer.
module tb_layer_compositor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    layer_compositor_if #(.NUM_LAYERS(4), .CW(8), .AW(8)) bus();

    layer_compositor dut (
        .clk (clk),
        .rst (rst),
        .px  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_layer(input int k, input logic [23:0] rgb, input logic [7:0] a);
        bus.i_layer_rgb[k*24 +: 24] = rgb;
        bus.i_layer_alpha[k*8 +: 8] = a;
    endtask

    task automatic test_reset();
        bus.i_de = 1'b0; bus.i_hs = 1'b0; bus.i_vs = 1'b0;
        bus.i_frame_start = 1'b0; bus.i_fade_req = 1'b0;
        bus.i_layer_rgb = '0; bus.i_layer_alpha = '0;
        bus.i_layer_active = 4'b0000; bus.i_layer_en = 4'b1111;
        rst = 1'b1;
        tick(2);
        n_checks++;
        if ({bus.o_r, bus.o_g, bus.o_b, bus.o_de, bus.o_hs, bus.o_vs, bus.o_swap, bus.o_busy} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rgb=%h de=%b swap=%b busy=%b, want all 0",
                     {bus.o_r, bus.o_g, bus.o_b}, bus.o_de, bus.o_swap, bus.o_busy);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_background();
        tick(6);
        bus.i_de = 1'b1; bus.i_hs = 1'b1; bus.i_vs = 1'b0;
        tick(4);
        n_checks++;
        if (bus.o_de !== 1'b0 || bus.o_hs !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: got de=%b hs=%b at 4 clocks, want 0/0", bus.o_de, bus.o_hs);
        end
        tick(1);
        n_checks++;
        if ({bus.o_r, bus.o_g, bus.o_b} !== 24'h1A0A2E || bus.o_de !== 1'b1 || bus.o_hs !== 1'b1) begin
            n_fail++;
            $display("FAIL bg_at_5: got rgb=%h de=%b hs=%b, want 1a0a2e/1/1",
                     {bus.o_r, bus.o_g, bus.o_b}, bus.o_de, bus.o_hs);
        end
        bus.i_de = 1'b0; bus.i_hs = 1'b0; bus.i_vs = 1'b1;
        tick(5);
        n_checks++;
        if ({bus.o_r, bus.o_g, bus.o_b} !== 24'h000000 || bus.o_de !== 1'b0 || bus.o_vs !== 1'b1 || bus.o_hs !== 1'b0) begin
            n_fail++;
            $display("FAIL blank: got rgb=%h de=%b hs=%b vs=%b, want 000000/0/0/1",
                     {bus.o_r, bus.o_g, bus.o_b}, bus.o_de, bus.o_hs, bus.o_vs);
        end
        bus.i_vs = 1'b0;
        bus.i_de = 1'b1;
    endtask

    task automatic test_alpha();
        set_layer(1, 24'hFF0000, 8'hFF);
        bus.i_layer_active = 4'b0010;
        tick(5);
        n_checks++;
        if ({bus.o_r, bus.o_g, bus.o_b} !== 24'hFF0000) begin
            n_fail++;
            $display("FAIL opaque_l1: got %h want ff0000", {bus.o_r, bus.o_g, bus.o_b});
        end
        set_layer(1, 24'hFF0000, 8'h80);
        tick(5);
        n_checks++;
        if ({bus.o_r, bus.o_g, bus.o_b} !== 24'h8D0416) begin
            n_fail++;
            $display("FAIL half_alpha: got %h want 8d0416", {bus.o_r, bus.o_g, bus.o_b});
        end
        set_layer(1, 24'hFF0000, 8'h00);
        tick(5);
        n_checks++;
        if ({bus.o_r, bus.o_g, bus.o_b} !== 24'h1A0A2E) begin
            n_fail++;
            $display("FAIL zero_alpha: got %h want 1a0a2e", {bus.o_r, bus.o_g, bus.o_b});
        end
    endtask

    task automatic test_priority();
        bus.i_layer_rgb = '0; bus.i_layer_alpha = '0;
        set_layer(0, 24'hFF0000, 8'hFF);
        set_layer(3, 24'h00FF00, 8'hFF);
        bus.i_layer_active = 4'b1001; bus.i_layer_en = 4'b1111;
        tick(5);
        n_checks++;
        if ({bus.o_r, bus.o_g, bus.o_b} !== 24'h00FF00) begin
            n_fail++;
            $display("FAIL top_wins: got %h want 00ff00", {bus.o_r, bus.o_g, bus.o_b});
        end
        bus.i_layer_en = 4'b0111;
        tick(5);
        n_checks++;
        if ({bus.o_r, bus.o_g, bus.o_b} !== 24'hFF0000) begin
            n_fail++;
            $display("FAIL en_mask: got %h want ff0000", {bus.o_r, bus.o_g, bus.o_b});
        end
        bus.i_layer_active = 4'b1000;
        tick(5);
        n_checks++;
        if ({bus.o_r, bus.o_g, bus.o_b} !== 24'h1A0A2E) begin
            n_fail++;
            $display("FAIL mask_to_bg: got %h want 1a0a2e", {bus.o_r, bus.o_g, bus.o_b});
        end
    endtask

    task automatic test_fade();
        logic [7:0] exp_px   [9] = '{8'hBF, 8'h7E, 8'h3E, 8'h00, 8'h00, 8'h3F, 8'h80, 8'hC0, 8'hFF};
        logic       exp_swap [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       exp_busy [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bus.i_layer_rgb = '0; bus.i_layer_alpha = '0;
        set_layer(0, 24'hFFFFFF, 8'hFF);
        bus.i_layer_active = 4'b0001; bus.i_layer_en = 4'b1111; bus.i_de = 1'b1;
        tick(6);
        n_checks++;
        if ({bus.o_r, bus.o_g, bus.o_b} !== 24'hFFFFFF || bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL white_idle: got %h busy=%b want ffffff busy=0", {bus.o_r, bus.o_g, bus.o_b}, bus.o_busy);
        end
        bus.i_fade_req = 1'b1; tick(1); bus.i_fade_req = 1'b0;
        n_checks++;
        if (bus.o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_rise: got %b want 1", bus.o_busy);
        end
        for (int i = 0; i < 9; i++) begin
            tick(2);
            bus.i_frame_start = 1'b1; tick(1); bus.i_frame_start = 1'b0;
            n_checks++;
            if (bus.o_swap !== exp_swap[i] || bus.o_busy !== exp_busy[i]) begin
                n_fail++;
                $display("FAIL fade_step%0d_ctl: got swap=%b busy=%b want swap=%b busy=%b",
                         i, bus.o_swap, bus.o_busy, exp_swap[i], exp_busy[i]);
            end
            tick(1);
            n_checks++;
            if ({bus.o_r, bus.o_g, bus.o_b} !== {3{exp_px[i]}} || bus.o_swap !== 1'b0) begin
                n_fail++;
                $display("FAIL fade_step%0d_px: got %h swap=%b want %h swap=0",
                         i, {bus.o_r, bus.o_g, bus.o_b}, bus.o_swap, {3{exp_px[i]}});
            end
        end
    endtask

    task automatic test_reverse_and_abort();
        bus.i_fade_req = 1'b1; tick(1); bus.i_fade_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(2);
            bus.i_frame_start = 1'b1; tick(1); bus.i_frame_start = 1'b0;
        end
        tick(1);
        n_checks++;
        if ({bus.o_r, bus.o_g, bus.o_b} !== 24'h808080) begin
            n_fail++;
            $display("FAIL fade_in_128: got %h want 808080", {bus.o_r, bus.o_g, bus.o_b});
        end
        bus.i_fade_req = 1'b1; tick(1); bus.i_fade_req = 1'b0;
        tick(2);
        bus.i_frame_start = 1'b1; tick(1); bus.i_frame_start = 1'b0;
        n_checks++;
        if (bus.o_swap !== 1'b0 || bus.o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reverse_ctl: got swap=%b busy=%b want 0/1", bus.o_swap, bus.o_busy);
        end
        tick(1);
        n_checks++;
        if ({bus.o_r, bus.o_g, bus.o_b} !== 24'h3F3F3F) begin
            n_fail++;
            $display("FAIL reverse_64: got %h want 3f3f3f", {bus.o_r, bus.o_g, bus.o_b});
        end
        rst = 1'b1; tick(1); rst = 1'b0;
        n_checks++;
        if (bus.o_busy !== 1'b0 || {bus.o_r, bus.o_g, bus.o_b} !== 24'h000000 || bus.o_de !== 1'b0
            || dut.gain_q !== 8'hFF) begin
            n_fail++;
            $display("FAIL abort_reset: got busy=%b rgb=%h de=%b gain=%h want 0/000000/0/ff",
                     bus.o_busy, {bus.o_r, bus.o_g, bus.o_b}, bus.o_de, dut.gain_q);
        end
        tick(6);
        n_checks++;
        if ({bus.o_r, bus.o_g, bus.o_b} !== 24'hFFFFFF || bus.o_swap !== 1'b0) begin
            n_fail++;
            $display("FAIL after_abort: got %h swap=%b want ffffff swap=0", {bus.o_r, bus.o_g, bus.o_b}, bus.o_swap);
        end
    endtask

    task automatic test_req_with_frame_start();
        bus.i_fade_req = 1'b1; bus.i_frame_start = 1'b1;
        tick(1);
        bus.i_fade_req = 1'b0; bus.i_frame_start = 1'b0;
        n_checks++;
        if (bus.o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL coincident_busy: got %b want 1", bus.o_busy);
        end
        tick(2);
        n_checks++;
        if ({bus.o_r, bus.o_g, bus.o_b} !== 24'hFFFFFF) begin
            n_fail++;
            $display("FAIL coincident_nostep: got %h want ffffff", {bus.o_r, bus.o_g, bus.o_b});
        end
        bus.i_frame_start = 1'b1; tick(1); bus.i_frame_start = 1'b0;
        tick(1);
        n_checks++;
        if ({bus.o_r, bus.o_g, bus.o_b} !== 24'hBFBFBF) begin
            n_fail++;
            $display("FAIL coincident_next: got %h want bfbfbf", {bus.o_r, bus.o_g, bus.o_b});
        end
        rst = 1'b1; tick(1); rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_background();
        test_alpha();
        test_priority();
        test_fade();
        test_reverse_and_abort();
        test_req_with_frame_start();
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
